nes_poll_scheduler: RTL and testbench
=====================================

# nes_poll_scheduler

Sequencer that owns the `start_fetch_i`/`valid_o` handshake of `nes_controller_interface`. It issues fetches periodically or on demand, and merges requests that arrive while a fetch is busy. It captures `data_LIST_o` on completion and runs a two-sample agreement filter per controller. Downstream game logic sees stable button vectors plus one-cycle press/release pulses, so it never touches the serial interface directly.

## Interface
Parameters:
- `NUM_CONTROLLERS`, 4: controllers served; must match the interface instance.
- `POLL_PERIOD`, 16667: clock cycles between periodic fetch starts (≥ 32).
- `TIMEOUT`, 63: maximum cycles to wait in any handshake phase before aborting.

Ports (clock and reset first):
- `clk` in 1: single clock for all logic.
- `rst_ni` in 1: reset, synchronous, active-low.
- `poll_enable_i` in 1: enables the periodic timer.
- `poll_req_i` in 1: one-cycle on-demand fetch request.
- `start_fetch_o` in→out 1: drives interface `start_fetch_i`.
- `fetch_valid_i` in 1: interface `valid_o`.
- `fetch_data_i` in 8·N: interface `data_LIST_o`.
- `buttons_o` out 8·N: filtered button state, 1 = pressed.
- `pressed_o` out 8·N: one-cycle pulse on each 0→1 transition of `buttons_o`.
- `released_o` out 8·N: one-cycle pulse on each 1→0 transition of `buttons_o`.
- `update_o` out 1: one-cycle strobe after each successful capture.
- `busy_o` out 1: high in any state other than IDLE.
- `error_o` out 1: sticky handshake-timeout flag.

## Operation
Requests:
- The period counter reloads to `POLL_PERIOD-1` and counts down while `poll_enable_i` is high.
- The counter holds its value while `poll_enable_i` is low.
- When the counter reaches 0 it sets `pending` and reloads.
- `poll_req_i` also sets `pending`.
- Coincident timer and request events merge into one `pending`. `pending` holds at most one request; extra requests while it is set are dropped.

State machine:
- IDLE: if `pending` and `fetch_valid_i`, go to ISSUE and clear `pending`.
- ISSUE: assert `start_fetch_o` for exactly this cycle, then go to ARM.
- ARM: wait for `fetch_valid_i`=0, then go to BUSY. After `TIMEOUT` cycles, set `error_o` and go to IDLE.
- BUSY: wait for `fetch_valid_i`=1, then go to CAPTURE. Same timeout rule as ARM.
- CAPTURE: sample `fetch_data_i` as `raw`, update the filter, pulse `update_o`, then go to IDLE.
- A `pending` request set during ARM, BUSY or CAPTURE is serviced from IDLE on the following cycle.

Filter (per controller, per bit):
- `buttons_o` takes the new `raw` bit only when it equals the previous capture's `raw` bit; otherwise `buttons_o` holds.
- `pressed_o = new & ~old` and `released_o = ~new & old`, both registered and valid in the `update_o` cycle.
- Bit mapping: 7 A, 6 B, 5 Select, 4 Start, 3 Up, 2 Down, 1 Left, 0 Right.

Error handling:
- `error_o` clears on the next successful CAPTURE.
- An aborted fetch leaves `buttons_o` and the previous-`raw` register unchanged.

## Timing
- Reset values: all outputs 0; state IDLE; `pending`=0; counter=`POLL_PERIOD-1`; `raw`/previous registers 0.
- Reset asserted mid-fetch returns to IDLE next edge with no pulses. The interface resets on the same signal, so no stale handshake remains.
- Request-to-`start_fetch_o` latency: 2 cycles from `poll_req_i` (pending register, then ISSUE).
- CAPTURE is the first edge with `fetch_valid_i`=1 after BUSY.
- `update_o`, `pressed_o`, `released_o` and the new `buttons_o` are all visible in the same cycle, 1 cycle after CAPTURE.
- Both timeout counters are `$clog2(TIMEOUT+1)` bits wide and saturate.
- The period counter is `$clog2(POLL_PERIOD)` bits wide and wraps only by reload.
- `start_fetch_o` is never high in two consecutive cycles.

## Structure
- `nes_pkg`:
  - state enum: IDLE, ISSUE, ARM, BUSY, CAPTURE;
  - button bit-index localparams;
  - `NES_BUTTONS`=8.
- Sub-module `nes_button_filter`:
  - one 8-bit instance per controller, generated `NUM_CONTROLLERS` times;
  - inputs `clk`, `rst_ni`, capture strobe, 8-bit raw sample;
  - holds the previous-raw register, filtered state and edge-pulse logic.
- Top level: timer, pending flag, FSM, timeout counters, error flag.

## Test plan
- Periodic polling: `POLL_PERIOD`=32, `poll_enable_i`=1, behavioural interface model → `start_fetch_o` pulses exactly 32 cycles apart, `update_o` once per fetch.
- Filtering: controller 0 returns 0x80, 0x80, then 0x00, 0x00 → `buttons_o[7:0]` goes 0x00 after the first capture, 0x80 after the second, 0x00 after the fourth. `pressed_o[7]` pulses once at capture 2 and `released_o[7]` once at capture 4.
- Glitch rejection: samples 0x01, 0x00, 0x01 → `buttons_o` stays 0x00 and no pulses occur.
- Merged requests: `poll_req_i` in the same cycle as the timer zero, plus two further requests during BUSY → two fetches total, the second starting from IDLE right after `update_o`.
- Timeout: model never drops `fetch_valid_i` → `error_o`=1 after 63 ARM cycles, `buttons_o` unchanged. The next good fetch clears `error_o`.
- Reset mid-BUSY: drop `rst_ni` → all outputs 0, state IDLE next edge, no `update_o`.

Source files
------------

// File: rtl/nes_pkg.sv
// nes_pkg
// Shared definitions for the NES controller poll scheduler:
//   - NES_BUTTONS      : bits per controller sample
//   - BTN_*            : bit index of each button inside an 8-bit sample
//   - state_t          : poll sequencer states
package nes_pkg;

    localparam int NES_BUTTONS = 8;

    // Bit positions inside one controller's 8-bit sample (1 = pressed).
    localparam int BTN_A      = 7;
    localparam int BTN_B      = 6;
    localparam int BTN_SELECT = 5;
    localparam int BTN_START  = 4;
    localparam int BTN_UP     = 3;
    localparam int BTN_DOWN   = 2;
    localparam int BTN_LEFT   = 1;
    localparam int BTN_RIGHT  = 0;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE   = 3'd1,
        ARM     = 3'd2,
        BUSY    = 3'd3,
        CAPTURE = 3'd4
    } state_t;

endpackage

// File: rtl/nes_button_filter.sv
// nes_button_filter
// Two-sample agreement filter for one controller (8 buttons).
// A button bit only changes when two consecutive captures agree on it.
// Ports:
//   clk, rst_ni   : clock, synchronous active-low reset
//   capture_i     : one-cycle strobe, sample raw_i this edge
//   raw_i         : raw 8-bit controller sample
//   buttons_o     : filtered button state
//   pressed_o     : one-cycle pulse for each 0->1 transition of buttons_o
//   released_o    : one-cycle pulse for each 1->0 transition of buttons_o
module nes_button_filter
    import nes_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_ni,
    input  logic                   capture_i,
    input  logic [NES_BUTTONS-1:0] raw_i,
    output logic [NES_BUTTONS-1:0] buttons_o,
    output logic [NES_BUTTONS-1:0] pressed_o,
    output logic [NES_BUTTONS-1:0] released_o
);

    logic [NES_BUTTONS-1:0] r_prev_raw;
    logic [NES_BUTTONS-1:0] r_buttons;
    logic [NES_BUTTONS-1:0] r_pressed;
    logic [NES_BUTTONS-1:0] r_released;

    logic [NES_BUTTONS-1:0] w_agree;
    logic [NES_BUTTONS-1:0] w_next;

    // Per bit: take the new sample where it matches the previous capture,
    // otherwise keep the current filtered value.
    assign w_agree = ~(raw_i ^ r_prev_raw);
    assign w_next  = (w_agree & raw_i) | (~w_agree & r_buttons);

    always_ff @(posedge clk) begin
        if (!rst_ni) begin
            r_prev_raw <= '0;
            r_buttons  <= '0;
            r_pressed  <= '0;
            r_released <= '0;
        end else begin
            // Edge pulses default low so they last exactly one cycle.
            r_pressed  <= '0;
            r_released <= '0;
            if (capture_i) begin
                r_prev_raw <= raw_i;
                r_buttons  <= w_next;
                r_pressed  <= w_next & ~r_buttons;
                r_released <= ~w_next & r_buttons;
            end
        end
    end

    assign buttons_o  = r_buttons;
    assign pressed_o  = r_pressed;
    assign released_o = r_released;

endmodule

// File: rtl/nes_poll_scheduler.sv
// nes_poll_scheduler
// Owns the start/valid handshake of the NES serial controller interface.
// Fetches are started by a periodic timer or on demand; requests arriving
// while a fetch is in flight are merged into a single pending request.
// Captured samples go through a per-controller agreement filter.
//
// Handshake: start_fetch_o is a one-cycle pulse, only issued while the
// interface reports idle (fetch_valid_i=1). The interface acknowledges by
// dropping fetch_valid_i (ARM), and signals completion by raising it again
// (BUSY); fetch_data_i is sampled in the CAPTURE cycle that follows.
// Each wait phase aborts after TIMEOUT cycles and sets the sticky error_o.
//
// Ports:
//   clk, rst_ni    : clock, synchronous active-low reset
//   poll_enable_i  : enables the periodic timer
//   poll_req_i     : one-cycle on-demand fetch request
//   start_fetch_o  : to interface start_fetch_i
//   fetch_valid_i  : from interface valid_o
//   fetch_data_i   : from interface data_LIST_o (8 bits per controller)
//   buttons_o      : filtered buttons, 1 = pressed
//   pressed_o      : one-cycle 0->1 pulses of buttons_o
//   released_o     : one-cycle 1->0 pulses of buttons_o
//   update_o       : one-cycle strobe after each successful capture
//   busy_o         : sequencer not in IDLE
//   error_o        : sticky handshake timeout, cleared by next capture
//   state_o        : current sequencer state (debug)
module nes_poll_scheduler
    import nes_pkg::*;
#(
    parameter int NUM_CONTROLLERS = 4,
    parameter int POLL_PERIOD     = 16667,
    parameter int TIMEOUT         = 63
) (
    input  logic                                   clk,
    input  logic                                   rst_ni,
    input  logic                                   poll_enable_i,
    input  logic                                   poll_req_i,
    output logic                                   start_fetch_o,
    input  logic                                   fetch_valid_i,
    input  logic [NES_BUTTONS*NUM_CONTROLLERS-1:0] fetch_data_i,
    output logic [NES_BUTTONS*NUM_CONTROLLERS-1:0] buttons_o,
    output logic [NES_BUTTONS*NUM_CONTROLLERS-1:0] pressed_o,
    output logic [NES_BUTTONS*NUM_CONTROLLERS-1:0] released_o,
    output logic                                   update_o,
    output logic                                   busy_o,
    output logic                                   error_o,
    output state_t                                 state_o
);

    localparam int PW = $clog2(POLL_PERIOD);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [PW-1:0] PERIOD_RELOAD = PW'(POLL_PERIOD - 1);
    // Last count value before abort: the TIMEOUT-th wait cycle aborts.
    localparam logic [TW-1:0] TIMEOUT_LAST  = TW'(TIMEOUT - 1);

    function automatic logic [TW-1:0] sat_inc(input logic [TW-1:0] v);
        return (v == '1) ? v : v + TW'(1);
    endfunction

    state_t          r_state;
    logic [PW-1:0]   r_period_cnt;
    logic            r_pending;
    logic [TW-1:0]   r_arm_cnt;
    logic [TW-1:0]   r_busy_cnt;
    logic            r_start;
    logic            r_update;
    logic            r_error;

    logic            w_timer_hit;
    logic            w_issue;
    logic            w_capture;

    assign w_timer_hit = poll_enable_i && (r_period_cnt == '0);
    assign w_issue     = (r_state == IDLE) && r_pending && fetch_valid_i;
    assign w_capture   = (r_state == CAPTURE);

    // Period timer: counts down only while enabled, holds otherwise.
    always_ff @(posedge clk) begin
        if (!rst_ni) begin
            r_period_cnt <= PERIOD_RELOAD;
        end else if (poll_enable_i) begin
            if (r_period_cnt == '0) begin
                r_period_cnt <= PERIOD_RELOAD;
            end else begin
                r_period_cnt <= r_period_cnt - PW'(1);
            end
        end
    end

    // Single-entry request flag. A request landing in the same cycle the
    // flag is consumed is treated as a duplicate of the one being issued.
    always_ff @(posedge clk) begin
        if (!rst_ni) begin
            r_pending <= 1'b0;
        end else if (w_issue) begin
            r_pending <= 1'b0;
        end else if (w_timer_hit || poll_req_i) begin
            r_pending <= 1'b1;
        end
    end

    // Sequencer with registered strobes and timeout counters.
    always_ff @(posedge clk) begin
        if (!rst_ni) begin
            r_state    <= IDLE;
            r_start    <= 1'b0;
            r_update   <= 1'b0;
            r_error    <= 1'b0;
            r_arm_cnt  <= '0;
            r_busy_cnt <= '0;
        end else begin
            r_start  <= 1'b0;
            r_update <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_issue) begin
                        r_state <= ISSUE;
                        r_start <= 1'b1;
                    end
                end
                ISSUE: begin
                    r_state   <= ARM;
                    r_arm_cnt <= '0;
                end
                ARM: begin
                    if (!fetch_valid_i) begin
                        r_state    <= BUSY;
                        r_busy_cnt <= '0;
                    end else if (r_arm_cnt == TIMEOUT_LAST) begin
                        r_state <= IDLE;
                        r_error <= 1'b1;
                    end else begin
                        r_arm_cnt <= sat_inc(r_arm_cnt);
                    end
                end
                BUSY: begin
                    if (fetch_valid_i) begin
                        r_state <= CAPTURE;
                    end else if (r_busy_cnt == TIMEOUT_LAST) begin
                        r_state <= IDLE;
                        r_error <= 1'b1;
                    end else begin
                        r_busy_cnt <= sat_inc(r_busy_cnt);
                    end
                end
                CAPTURE: begin
                    r_state  <= IDLE;
                    r_update <= 1'b1;
                    r_error  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // One agreement filter per controller, all sampling in CAPTURE.
    for (genvar g = 0; g < NUM_CONTROLLERS; g++) begin : g_filter
        nes_button_filter u_filter (
            .clk        (clk),
            .rst_ni     (rst_ni),
            .capture_i  (w_capture),
            .raw_i      (fetch_data_i[g*NES_BUTTONS +: NES_BUTTONS]),
            .buttons_o  (buttons_o[g*NES_BUTTONS +: NES_BUTTONS]),
            .pressed_o  (pressed_o[g*NES_BUTTONS +: NES_BUTTONS]),
            .released_o (released_o[g*NES_BUTTONS +: NES_BUTTONS])
        );
    end

    assign start_fetch_o = r_start;
    assign update_o      = r_update;
    assign error_o       = r_error;
    assign busy_o        = (r_state != IDLE);
    assign state_o       = r_state;

endmodule

// File: tb/tb_nes_poll_scheduler.sv
module tb_nes_poll_scheduler;
  import nes_pkg::*;

  localparam int N = 4;
  localparam int W = 8 * N;

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  logic poll_enable_i = 1'b0;
  logic poll_req_i = 1'b0;
  logic fetch_valid_i = 1'b1;
  logic [W-1:0] fetch_data_i = '0;
  logic start_fetch_o, update_o, busy_o, error_o;
  logic [W-1:0] buttons_o, pressed_o, released_o;
  state_t state_o;

  int n_pass = 0;
  int n_total = 0;

  nes_poll_scheduler #(
    .NUM_CONTROLLERS(N),
    .POLL_PERIOD(32),
    .TIMEOUT(63)
  ) dut (
    .clk(clk),
    .rst_ni(rst_ni),
    .poll_enable_i(poll_enable_i),
    .poll_req_i(poll_req_i),
    .start_fetch_o(start_fetch_o),
    .fetch_valid_i(fetch_valid_i),
    .fetch_data_i(fetch_data_i),
    .buttons_o(buttons_o),
    .pressed_o(pressed_o),
    .released_o(released_o),
    .update_o(update_o),
    .busy_o(busy_o),
    .error_o(error_o),
    .state_o(state_o)
  );

  // ---------------- clock / reset / cycle counter ----------------
  initial forever #5 clk = ~clk;

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- behavioural interface model ----------------
  int m_len = 4;
  bit m_stuck = 1'b0;
  logic [W-1:0] m_data = '0;
  int m_cnt = 0;

  initial forever begin
    @(negedge clk);
    if (!rst_ni) begin
      m_cnt = 0;
      fetch_valid_i = 1'b1;
    end else if (m_cnt > 0) begin
      m_cnt--;
      if (m_cnt == 0) begin
        fetch_data_i = m_data;
        fetch_valid_i = 1'b1;
      end
    end else if (start_fetch_o && !m_stuck) begin
      fetch_valid_i = 1'b0;
      m_cnt = m_len;
    end
  end

  // ---------------- monitor ----------------
  int start_q[$];
  int upd_q[$];
  int n_consec = 0;
  bit prev_start = 1'b0;

  initial forever begin
    @(negedge clk);
    if (start_fetch_o) begin
      start_q.push_back(cyc);
      if (prev_start) n_consec++;
    end
    if (update_o) upd_q.push_back(cyc);
    prev_start = start_fetch_o;
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst_ni = 1'b0;
    repeat (3) @(negedge clk);
    rst_ni = 1'b1;
    @(negedge clk);
  endtask

  // Requests one fetch returning data; returns at the negedge where update_o is high.
  task automatic do_fetch(input logic [W-1:0] data);
    bit seen;
    m_data = data;
    poll_req_i = 1'b1;
    @(negedge clk);
    poll_req_i = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (update_o) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!seen) begin
      n_total++;
      $display("FAIL fetch_wait: update_o got=0 required=1 within 60 cycles");
    end
  endtask

  task automatic wait_state(input state_t s);
    for (int i = 0; i < 20; i++) begin
      if (state_o == s) break;
      @(negedge clk);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_ni = 1'b0;
    repeat (3) @(negedge clk);
    n_total++; if (buttons_o !== '0 || pressed_o !== '0 || released_o !== '0)
      $display("FAIL reset_vectors: got b=%h p=%h r=%h required 0", buttons_o, pressed_o, released_o); else n_pass++;
    rst_ni = 1'b1;
    @(negedge clk);
    n_total++; if ({start_fetch_o, update_o, busy_o, error_o} !== 4'b0000)
      $display("FAIL reset_flags: got %b required 0000", {start_fetch_o, update_o, busy_o, error_o}); else n_pass++;
    n_total++; if (state_o !== IDLE)
      $display("FAIL reset_state: got %0d required %0d", state_o, IDLE); else n_pass++;
  endtask

  task automatic test_latency();
    m_data = '0;
    poll_req_i = 1'b1;
    @(negedge clk);
    poll_req_i = 1'b0;
    n_total++; if (start_fetch_o !== 1'b0)
      $display("FAIL latency_cycle1: start got=%b required 0", start_fetch_o); else n_pass++;
    @(negedge clk);
    n_total++; if (start_fetch_o !== 1'b1 || state_o !== ISSUE)
      $display("FAIL latency_cycle2: start got=%b state=%0d required 1/%0d", start_fetch_o, state_o, ISSUE); else n_pass++;
    n_total++; if (busy_o !== 1'b1)
      $display("FAIL busy_issue: got=%b required 1", busy_o); else n_pass++;
    @(negedge clk);
    n_total++; if (start_fetch_o !== 1'b0 || state_o !== ARM)
      $display("FAIL start_single: start got=%b state=%0d required 0/%0d", start_fetch_o, state_o, ARM); else n_pass++;
    for (int i = 0; i < 20 && !update_o; i++) @(negedge clk);
    n_total++; if (update_o !== 1'b1 || state_o !== IDLE)
      $display("FAIL latency_update: update got=%b state=%0d required 1/%0d", update_o, state_o, IDLE); else n_pass++;
    @(negedge clk);
    n_total++; if (update_o !== 1'b0)
      $display("FAIL update_pulse: got=%b required 0", update_o); else n_pass++;
  endtask

  task automatic test_filter();
    logic [7:0] raws [4];
    logic [7:0] eb [4];
    logic [7:0] ep [4];
    logic [7:0] er [4];
    raws = '{8'h80, 8'h80, 8'h00, 8'h00};
    eb   = '{8'h00, 8'h80, 8'h80, 8'h00};
    ep   = '{8'h00, 8'h80, 8'h00, 8'h00};
    er   = '{8'h00, 8'h00, 8'h00, 8'h80};
    for (int i = 0; i < 4; i++) begin
      do_fetch({24'h0, raws[i]});
      n_total++; if (buttons_o !== {24'h0, eb[i]})
        $display("FAIL filter_buttons[%0d]: got %h required %h", i, buttons_o, {24'h0, eb[i]}); else n_pass++;
      n_total++; if (pressed_o !== {24'h0, ep[i]} || released_o !== {24'h0, er[i]})
        $display("FAIL filter_edges[%0d]: got p=%h r=%h required p=%h r=%h", i, pressed_o, released_o, ep[i], er[i]); else n_pass++;
      @(negedge clk);
      n_total++; if (pressed_o !== '0 || released_o !== '0)
        $display("FAIL filter_pulse_len[%0d]: got p=%h r=%h required 0", i, pressed_o, released_o); else n_pass++;
    end
  endtask

  task automatic test_glitch();
    logic [7:0] raws [3];
    raws = '{8'h01, 8'h00, 8'h01};
    for (int i = 0; i < 3; i++) begin
      do_fetch({24'h0, raws[i]});
      n_total++; if (buttons_o !== '0 || pressed_o !== '0 || released_o !== '0)
        $display("FAIL glitch[%0d]: got b=%h p=%h r=%h required 0", i, buttons_o, pressed_o, released_o); else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    do_fetch(32'h1234_5678);
    n_total++; if (buttons_o !== 32'h0)
      $display("FAIL b2b_first: got %h required 00000000", buttons_o); else n_pass++;
    do_fetch(32'h1234_5678);
    n_total++; if (buttons_o !== 32'h1234_5678 || pressed_o !== 32'h1234_5678 || released_o !== 32'h0)
      $display("FAIL b2b_second: got b=%h p=%h r=%h required 12345678/12345678/0", buttons_o, pressed_o, released_o); else n_pass++;
  endtask

  task automatic test_timeout();
    int upd_before;
    m_stuck = 1'b1;
    poll_req_i = 1'b1;
    @(negedge clk);
    poll_req_i = 1'b0;
    wait_state(ARM);
    upd_before = upd_q.size();
    repeat (62) @(negedge clk);
    n_total++; if (state_o !== ARM || error_o !== 1'b0)
      $display("FAIL timeout_early: state=%0d err=%b required %0d/0", state_o, error_o, ARM); else n_pass++;
    @(negedge clk);
    n_total++; if (error_o !== 1'b1 || state_o !== IDLE)
      $display("FAIL timeout_abort: err=%b state=%0d required 1/%0d", error_o, state_o, IDLE); else n_pass++;
    n_total++; if (buttons_o !== 32'h1234_5678)
      $display("FAIL timeout_buttons: got %h required 12345678", buttons_o); else n_pass++;
    m_stuck = 1'b0;
    repeat (5) @(negedge clk);
    n_total++; if (error_o !== 1'b1 || upd_q.size() != upd_before)
      $display("FAIL timeout_sticky: err=%b updates=%0d required 1/%0d", error_o, upd_q.size(), upd_before); else n_pass++;
    do_fetch(32'h1234_5678);
    n_total++; if (error_o !== 1'b0)
      $display("FAIL timeout_clear: err got=%b required 0", error_o); else n_pass++;
    n_total++; if (buttons_o !== 32'h1234_5678 || pressed_o !== '0)
      $display("FAIL timeout_prev_kept: got b=%h p=%h required 12345678/0", buttons_o, pressed_o); else n_pass++;
  endtask

  task automatic test_periodic();
    int c0;
    do_reset();
    start_q.delete();
    upd_q.delete();
    m_data = '0;
    c0 = cyc;
    poll_enable_i = 1'b1;
    repeat (138) @(negedge clk);
    poll_enable_i = 1'b0;
    repeat (20) @(negedge clk);
    n_total++; if (start_q.size() != 4 || upd_q.size() != 4)
      $display("FAIL periodic_count: starts=%0d updates=%0d required 4/4", start_q.size(), upd_q.size()); else n_pass++;
    if (start_q.size() == 4) begin
      n_total++; if (start_q[0] != c0 + 33)
        $display("FAIL periodic_first: got cycle %0d required %0d", start_q[0], c0 + 33); else n_pass++;
      for (int i = 1; i < 4; i++) begin
        n_total++; if (start_q[i] - start_q[i-1] != 32)
          $display("FAIL periodic_interval[%0d]: got %0d required 32", i, start_q[i] - start_q[i-1]); else n_pass++;
      end
    end
  endtask

  task automatic test_merged();
    do_reset();
    start_q.delete();
    upd_q.delete();
    m_len = 8;
    poll_enable_i = 1'b1;
    repeat (31) @(negedge clk);
    poll_req_i = 1'b1;
    @(negedge clk);
    poll_req_i = 1'b0;
    poll_enable_i = 1'b0;
    wait_state(BUSY);
    poll_req_i = 1'b1;
    @(negedge clk);
    poll_req_i = 1'b0;
    @(negedge clk);
    poll_req_i = 1'b1;
    @(negedge clk);
    poll_req_i = 1'b0;
    n_total++; if (state_o !== BUSY)
      $display("FAIL merged_in_busy: state got=%0d required %0d", state_o, BUSY); else n_pass++;
    repeat (60) @(negedge clk);
    n_total++; if (start_q.size() != 2 || upd_q.size() != 2)
      $display("FAIL merged_count: starts=%0d updates=%0d required 2/2", start_q.size(), upd_q.size()); else n_pass++;
    if (start_q.size() == 2 && upd_q.size() == 2) begin
      n_total++; if (start_q[1] != upd_q[0] + 1)
        $display("FAIL merged_restart: start at %0d required %0d", start_q[1], upd_q[0] + 1); else n_pass++;
    end
    m_len = 4;
  endtask

  task automatic test_reset_mid_busy();
    int upd_before;
    do_fetch(32'hA5A5_A5A5);
    do_fetch(32'hA5A5_A5A5);
    n_total++; if (buttons_o !== 32'hA5A5_A5A5)
      $display("FAIL rst_pre_buttons: got %h required a5a5a5a5", buttons_o); else n_pass++;
    m_len = 8;
    m_data = 32'h0F0F_0F0F;
    poll_req_i = 1'b1;
    @(negedge clk);
    poll_req_i = 1'b0;
    wait_state(BUSY);
    upd_before = upd_q.size();
    rst_ni = 1'b0;
    @(negedge clk);
    n_total++; if (buttons_o !== '0 || pressed_o !== '0 || released_o !== '0)
      $display("FAIL rst_busy_vectors: got b=%h p=%h r=%h required 0", buttons_o, pressed_o, released_o); else n_pass++;
    n_total++; if (state_o !== IDLE || {start_fetch_o, update_o, busy_o, error_o} !== 4'b0000)
      $display("FAIL rst_busy_state: state=%0d flags=%b required %0d/0000", state_o, {start_fetch_o, update_o, busy_o, error_o}, IDLE); else n_pass++;
    rst_ni = 1'b1;
    repeat (20) @(negedge clk);
    n_total++; if (upd_q.size() != upd_before || state_o !== IDLE)
      $display("FAIL rst_busy_no_update: updates=%0d state=%0d required %0d/%0d", upd_q.size(), state_o, upd_before, IDLE); else n_pass++;
    m_len = 4;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_latency();
    test_filter();
    test_glitch();
    test_back_to_back();
    test_timeout();
    test_periodic();
    test_merged();
    test_reset_mid_busy();
    n_total++; if (n_consec != 0)
      $display("FAIL start_consecutive: got %0d back-to-back start cycles required 0", n_consec); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
